// File: rtl/tx_pattern_gen.sv
// Transceiver TX pattern generator: IDLE/ALIGN comma framing, then counter/PRBS-7/PRBS-31 data
// with periodic comma insertion. Define TX_PATTERN_GEN_ERR_INJECT_EN to enable error injection.
module tx_pattern_gen #(
    parameter int unsigned COMMA_PERIOD = 256,
    parameter int unsigned ALIGN_WORDS  = 16
) (
    input  logic        txclk,
    input  logic        rst_n,
    input  logic        ctrl_enable,
    input  logic [1:0]  ctrl_mode,
    input  logic        ctrl_inject_err,
    input  logic        ctrl_clear,
    input  logic        tx_ready,
    output logic [15:0] tx_data,
    output logic [1:0]  tx_charisk,
    output logic [47:0] tx_cnt,
    output logic [15:0] tx_err_injected,
    output logic [1:0]  tx_state
);

    localparam logic [15:0] CommaWord  = 16'hBC50;
    localparam logic [1:0]  CommaK     = 2'b10;
    localparam logic [15:0] PeriodLast = 16'(COMMA_PERIOD - 1);
    localparam logic [7:0]  AlignLast  = 8'(ALIGN_WORDS - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StAlign = 2'b01,
        StRun   = 2'b10
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  rst_sync_q;
    logic [7:0]  align_q, align_d;
    logic [15:0] period_q, period_d;
    logic [1:0]  mode_q, mode_d;
    logic [15:0] ctr_q, ctr_d, ctr_base;
    logic [6:0]  prbs7_q, prbs7_d, base7, next7;
    logic [30:0] prbs31_q, prbs31_d, base31, next31;
    logic [15:0] w7, w31, word;
    logic [15:0] data_q, data_d;
    logic [1:0]  k_q, k_d;
    logic [47:0] cnt_q, cnt_d;
    logic [15:0] err_q, err_d;
    logic        go, run_entry, is_data, inj;

    // Reset asserts asynchronously but the FSM only leaves IDLE once release has crossed two flops
    always_ff @(posedge txclk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign go        = ctrl_enable & tx_ready;
    assign run_entry = (state_q == StAlign) && (align_q == '0);
    assign ctr_base  = run_entry ? 16'h0000 : ctr_q;
    assign base7     = run_entry ? '1 : prbs7_q;
    assign base31    = run_entry ? '1 : prbs31_q;

    // 16 serial LFSR steps per word; the earliest generated bit lands in [15]
    always_comb begin
        logic [6:0]  s7;
        logic [30:0] s31;
        s7  = base7;
        s31 = base31;
        w7  = '0;
        w31 = '0;
        for (int i = 0; i < 16; i++) begin
            w7[15-i]  = s7[6] ^ s7[5];
            s7        = {s7[5:0], s7[6] ^ s7[5]};
            w31[15-i] = s31[30] ^ s31[27];
            s31       = {s31[29:0], s31[30] ^ s31[27]};
        end
        next7  = s7;
        next31 = s31;
    end

`ifdef TX_PATTERN_GEN_ERR_INJECT_EN
    logic inj_prev_q, pend_q, pend_d, inj_req;

    always_ff @(posedge txclk or negedge rst_n) begin
        if (!rst_n) begin
            inj_prev_q <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            inj_prev_q <= ctrl_inject_err;
            pend_q     <= pend_d;
        end
    end
`else
    logic unused_inject;
    assign unused_inject = ctrl_inject_err;
`endif

    always_comb begin
        state_d  = state_q;
        align_d  = align_q;
        mode_d   = mode_q;
        period_d = '0;
        ctr_d    = ctr_q;
        prbs7_d  = prbs7_q;
        prbs31_d = prbs31_q;
        data_d   = CommaWord;
        k_d      = CommaK;
        cnt_d    = cnt_q;
        err_d    = err_q;
        is_data  = 1'b0;
        word     = ctr_base;

        unique case (state_q)
            StIdle: begin
                if (go && rst_sync_q[1]) begin
                    state_d = StAlign;
                    align_d = AlignLast;
                    mode_d  = (ctrl_mode == 2'b11) ? 2'b00 : ctrl_mode;
                end
            end
            StAlign: begin
                if (align_q == '0) state_d = StRun;
                else               align_d = align_q - 8'd1;
            end
            StRun:   state_d = StRun;
            default: state_d = StIdle;
        endcase
        if (!go) state_d = StIdle;

        // period_d is the position of the emitted word within the comma period; 0 marks a comma
        if (state_d == StRun) begin
            if (run_entry)                 period_d = 16'd1;
            else if (period_q != PeriodLast) period_d = period_q + 16'd1;
            is_data = (period_d != '0);
        end

`ifdef TX_PATTERN_GEN_ERR_INJECT_EN
        inj_req = pend_q | (ctrl_inject_err & ~inj_prev_q);
        inj     = inj_req & is_data;
        pend_d  = inj_req & ~is_data;
        if (inj && err_q != 16'hFFFF) err_d = err_q + 16'd1;
`else
        inj   = 1'b0;
        err_d = '0;
`endif

        if (is_data) begin
            case (mode_q)
                2'b01:   word = w7;
                2'b10:   word = w31;
                default: word = ctr_base;
            endcase
            ctr_d    = ctr_base + 16'd1;
            prbs7_d  = next7;
            prbs31_d = next31;
            cnt_d    = cnt_q + 48'd1;
            data_d   = word ^ {15'd0, inj};
            k_d      = 2'b00;
        end

        if (ctrl_clear) begin
            cnt_d = '0;
            err_d = '0;
        end
    end

    always_ff @(posedge txclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            align_q  <= '0;
            period_q <= '0;
            mode_q   <= '0;
            ctr_q    <= '0;
            prbs7_q  <= '1;
            prbs31_q <= '1;
            data_q   <= CommaWord;
            k_q      <= CommaK;
            cnt_q    <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            align_q  <= align_d;
            period_q <= period_d;
            mode_q   <= mode_d;
            ctr_q    <= ctr_d;
            prbs7_q  <= prbs7_d;
            prbs31_q <= prbs31_d;
            data_q   <= data_d;
            k_q      <= k_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    assign tx_data         = data_q;
    assign tx_charisk      = k_q;
    assign tx_cnt          = cnt_q;
    assign tx_err_injected = err_q;
    assign tx_state        = state_q;

endmodule

// File: tb/tb_tx_pattern_gen.sv
// Bench for tx_pattern_gen: two instances (default and short period/align) checked every cycle
// against a bit-sequence model, plus hand-computed expectations from directed stimulus.
`timescale 1ns/1ps
module tb_tx_pattern_gen;

`ifdef TX_PATTERN_GEN_ERR_INJECT_EN
    localparam bit InjEn = 1'b1;
`else
    localparam bit InjEn = 1'b0;
`endif

    logic       txclk;
    logic       rst_n;
    logic       ctrl_enable;
    logic [1:0] ctrl_mode;
    logic       ctrl_inject_err;
    logic       ctrl_clear;
    logic       tx_ready;

    int n_tests = 0;
    int n_fail  = 0;

    bit p7  [32768];
    bit p31 [32768];

    initial txclk = 1'b0;
    always #5 txclk = ~txclk;

    // PRBS bit sequences: b[n] = b[n-7]^b[n-6] and b[n] = b[n-31]^b[n-28], history all ones
    initial begin
        for (int i = 0; i < 32768; i++) begin
            p7[i]  = ((i >= 7) ? p7[i-7] : 1'b1) ^ ((i >= 6) ? p7[i-6] : 1'b1);
            p31[i] = ((i >= 31) ? p31[i-31] : 1'b1) ^ ((i >= 28) ? p31[i-28] : 1'b1);
        end
    end

    function automatic logic [15:0] pat_word(int mode, int n);
        logic [15:0] w;
        w = '0;
        if (mode == 0) return 16'(n);
        if (n >= 2048) return 16'hDEAD;
        for (int j = 0; j < 16; j++) w[15-j] = (mode == 1) ? p7[n*16+j] : p31[n*16+j];
        return w;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int P = (g == 0) ? 256 : 4;
        localparam int A = (g == 0) ? 16 : 3;

        logic [15:0] dut_data;
        logic [1:0]  dut_k;
        logic [47:0] dut_cnt;
        logic [15:0] dut_err;
        logic [1:0]  dut_state;

        tx_pattern_gen #(.COMMA_PERIOD(P), .ALIGN_WORDS(A)) u_dut (
            .txclk          (txclk),
            .rst_n          (rst_n),
            .ctrl_enable    (ctrl_enable),
            .ctrl_mode      (ctrl_mode),
            .ctrl_inject_err(ctrl_inject_err),
            .ctrl_clear     (ctrl_clear),
            .tx_ready       (tx_ready),
            .tx_data        (dut_data),
            .tx_charisk     (dut_k),
            .tx_cnt         (dut_cnt),
            .tx_err_injected(dut_err),
            .tx_state       (dut_state)
        );

        int          m_st = 0, m_rel = 0, m_asent = 0, m_ridx = 0, m_n = 0, m_mode = 0;
        bit          m_prev = 0, m_pend = 0, m_go = 0, m_rise = 0;
        logic [15:0] m_w;
        logic [15:0] e_data = 16'hBC50;
        logic [1:0]  e_k    = 2'b10;
        logic [47:0] e_cnt  = '0;
        logic [15:0] e_err  = '0;

        initial forever begin
            @(posedge txclk);
            if (!rst_n) begin
                m_st = 0; m_rel = 0; m_prev = 0; m_pend = 0;
                e_data = 16'hBC50; e_k = 2'b10; e_cnt = '0; e_err = '0;
            end else begin
                m_go = (m_rel >= 2);
                if (m_rel < 2) m_rel++;
                m_rise = ctrl_inject_err && !m_prev;
                m_prev = ctrl_inject_err;
                if (m_rise && InjEn) m_pend = 1;
                if (!(ctrl_enable && tx_ready)) m_st = 0;
                else if (m_st == 0) begin
                    if (m_go) begin
                        m_st = 1; m_asent = 1;
                        m_mode = (ctrl_mode == 2'b11) ? 0 : int'(ctrl_mode);
                    end
                end else if (m_st == 1) begin
                    if (m_asent == A) begin m_st = 2; m_ridx = 1; m_n = 0; end
                    else m_asent++;
                end else m_ridx++;
                if (m_st == 2 && (m_ridx % P) != 0) begin
                    m_w = pat_word(m_mode, m_n);
                    m_n++;
                    if (m_pend) begin
                        m_w[0] = ~m_w[0];
                        m_pend = 0;
                        if (e_err != 16'hFFFF) e_err = e_err + 16'd1;
                    end
                    e_data = m_w; e_k = 2'b00; e_cnt = e_cnt + 48'd1;
                end else begin
                    e_data = 16'hBC50; e_k = 2'b10;
                end
                if (ctrl_clear) begin e_cnt = '0; e_err = '0; end
            end
        end

        initial forever begin
            @(posedge txclk);
            #2;
            n_tests++;
            if (dut_data !== e_data || dut_k !== e_k || dut_cnt !== e_cnt || dut_err !== e_err ||
                dut_state !== 2'(m_st)) begin
                n_fail++;
                if (n_fail < 30)
                    $display("FAIL model[%0d] t=%0t: got data=%h k=%b cnt=%0d err=%0d st=%0d, required data=%h k=%b cnt=%0d err=%0d st=%0d",
                             g, $time, dut_data, dut_k, dut_cnt, dut_err, dut_state,
                             e_data, e_k, e_cnt, e_err, m_st);
            end
        end
    end

    logic [17:0] q1[$];
    logic [17:0] exp1 [8];
    bit          collect1 = 0;
    int          aligned, words;

    task automatic step();
        @(posedge txclk);
        #3;
    endtask

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic wait_run(output int na);
        int budget;
        na = 0;
        budget = 0;
        while (g_inst[0].dut_state != 2'b10 && budget < 300) begin
            step();
            budget++;
            if (g_inst[0].dut_state == 2'b01) na++;
            if (collect1 && g_inst[1].dut_state == 2'b10 && q1.size() < 8)
                q1.push_back({g_inst[1].dut_k, g_inst[1].dut_data});
        end
        if (g_inst[0].dut_state != 2'b10) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_run: state=%0d required 2", g_inst[0].dut_state);
        end
    endtask

    task automatic check_reset_vals(string name);
        check({name, "_data"}, 64'(g_inst[0].dut_data), 64'hBC50);
        check({name, "_k"}, 64'(g_inst[0].dut_k), 64'h2);
        check({name, "_cnt"}, 64'(g_inst[0].dut_cnt), 64'h0);
        check({name, "_err"}, 64'(g_inst[0].dut_err), 64'h0);
        check({name, "_state"}, 64'(g_inst[0].dut_state), 64'h0);
    endtask

    initial begin
        exp1 = '{18'h00000, 18'h00001, 18'h00002, 18'h2BC50,
                 18'h00003, 18'h00004, 18'h00005, 18'h2BC50};
        rst_n = 1; ctrl_enable = 0; ctrl_mode = 2'b00; ctrl_inject_err = 0;
        ctrl_clear = 0; tx_ready = 0;
        #1 rst_n = 0;
        repeat (3) step();
        check_reset_vals("reset");

        // Counter mode bring-up
        rst_n = 1; ctrl_enable = 1; tx_ready = 1;
        collect1 = 1;
        wait_run(aligned);
        collect1 = 0;
        check("align_words", 64'(aligned), 64'd16);
        check("first_word", 64'(g_inst[0].dut_data), 64'h0000);
        check("first_k", 64'(g_inst[0].dut_k), 64'h0);
        check("first_cnt", 64'(g_inst[0].dut_cnt), 64'd1);
        check("p4_words_seen", 64'(q1.size()), 64'd8);
        for (int i = 0; i < 8 && i < q1.size(); i++)
            check($sformatf("p4_word%0d", i), 64'(q1[i]), 64'(exp1[i]));

        // Error injection on word 5 -> 6 goes out as 7
        repeat (5) step();
        check("word5", 64'(g_inst[0].dut_data), 64'h0005);
        ctrl_inject_err = 1;
        step();
        ctrl_inject_err = 0;
        check("inject_word", 64'(g_inst[0].dut_data), InjEn ? 64'h0007 : 64'h0006);
        step();
        check("after_inject", 64'(g_inst[0].dut_data), 64'h0007);
        check("err_count", 64'(g_inst[0].dut_err), InjEn ? 64'd1 : 64'd0);
        repeat (2) step();
        check("word9", 64'(g_inst[0].dut_data), 64'h0009);
        check("cnt10", 64'(g_inst[0].dut_cnt), 64'd10);

        // Clear coincident with a data word
        ctrl_clear = 1;
        step();
        ctrl_clear = 0;
        check("clear_cnt", 64'(g_inst[0].dut_cnt), 64'd0);
        check("clear_err", 64'(g_inst[0].dut_err), 64'd0);
        step();
        check("cnt_after_clear", 64'(g_inst[0].dut_cnt), 64'd1);

        // Mode change during RUN is ignored
        ctrl_mode = 2'b01;
        repeat (3) step();
        check("mode_ignored", 64'(g_inst[0].dut_data), 64'h000E);

        // tx_ready drop -> IDLE commas next cycle; re-entry picks up PRBS-7
        tx_ready = 0;
        step();
        check("drop_state", 64'(g_inst[0].dut_state), 64'h0);
        check("drop_data", 64'({g_inst[0].dut_k, g_inst[0].dut_data}), 64'h2BC50);
        tx_ready = 1;
        wait_run(aligned);
        check("prbs7_first", 64'(g_inst[0].dut_data), 64'h020C);
        words = 1;
        for (int c = 0; c < 1200 && words < 1000; c++) begin
            step();
            if (g_inst[0].dut_k == 2'b00) words++;
        end
        check("prbs7_words", 64'(words), 64'd1000);
        ctrl_enable = 0;
        step();
        check("disable_state", 64'(g_inst[0].dut_state), 64'h0);
        ctrl_enable = 1;
        wait_run(aligned);
        check("prbs7_restart", 64'(g_inst[0].dut_data), 64'h020C);

        // PRBS-31
        ctrl_enable = 0; ctrl_mode = 2'b10;
        step();
        ctrl_enable = 1;
        wait_run(aligned);
        check("prbs31_w0", 64'(g_inst[0].dut_data), 64'h0000);
        step();
        check("prbs31_w1", 64'(g_inst[0].dut_data), 64'h000E);

        // Mode 11 acts as counter; injection requested in IDLE stays pending
        ctrl_enable = 0; ctrl_mode = 2'b11;
        step();
        ctrl_inject_err = 1;
        step();
        ctrl_inject_err = 0;
        step();
        ctrl_enable = 1;
        wait_run(aligned);
        check("pending_inj", 64'(g_inst[0].dut_data), InjEn ? 64'h0001 : 64'h0000);
        step();
        check("mode3_w1", 64'(g_inst[0].dut_data), 64'h0001);
        check("pending_err", 64'(g_inst[0].dut_err), InjEn ? 64'd1 : 64'd0);

        // Asynchronous reset mid-RUN, then synchronised release
        repeat (3) step();
        rst_n = 0;
        #1;
        check_reset_vals("async_reset");
        repeat (2) step();
        rst_n = 1;
        step();
        check("sync_hold1", 64'(g_inst[0].dut_state), 64'h0);
        step();
        check("sync_hold2", 64'(g_inst[0].dut_state), 64'h0);
        step();
        check("sync_go", 64'(g_inst[0].dut_state), 64'h1);
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_pattern_gen.md
TX_PATTERN_GEN -- requirements
Module: tx_pattern_gen

Interface
REQ-001 SHALL have parameter COMMA_PERIOD, default 256, meaning RUN-state words between inserted comma words (legal 2..65535).
REQ-002 SHALL have parameter ALIGN_WORDS, default 16, meaning comma words sent in ALIGN before data (legal 1..255).
REQ-003 SHALL have port txclk  input  1  transmit clock; all logic is in this single domain.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port ctrl_enable  input  1  run request (VIO-driven, level).
REQ-006 SHALL have port ctrl_mode  input  2  pattern select: 00 counter, 01 PRBS-7, 10 PRBS-31, 11 treated as 00.
REQ-007 SHALL have port ctrl_inject_err  input  1  error-injection request (rising edge).
REQ-008 SHALL have port ctrl_clear  input  1  synchronous clear of tx_cnt and tx_err_injected.
REQ-009 SHALL have port tx_ready  input  1  transceiver TX lane ready.
REQ-010 SHALL have port tx_data  output  16  word to transceiver, [15:8] sent first.
REQ-011 SHALL have port tx_charisk  output  2  K-character flags, bit1 for [15:8], bit0 for [7:0].
REQ-012 SHALL have port tx_cnt  output  48  data words sent since reset/clear.
REQ-013 SHALL have port tx_err_injected  output  16  injected error count.
REQ-014 SHALL have port tx_state  output  2  FSM state: 00 IDLE, 01 ALIGN, 10 RUN.

Function
REQ-015 All outputs SHALL be registered; a state/pattern change is visible on tx_data one txclk after the cycle that causes it.
REQ-016 Comma word SHALL be tx_data=16'hBC50, tx_charisk=2'b10 (K28.5, D16.2).
REQ-017 IDLE: SHALL emit comma words; go to ALIGN when ctrl_enable=1 and tx_ready=1.
REQ-018 ALIGN: SHALL emit exactly ALIGN_WORDS comma words, then go to RUN; ctrl_mode SHALL be latched on ALIGN entry.
REQ-019 RUN: SHALL emit data words with tx_charisk=2'b00, except every COMMA_PERIOD-th cycle, which emits one comma word.
REQ-020 Comma cycles in RUN SHALL neither advance the pattern nor increment tx_cnt.
REQ-021 Counter mode: first data word SHALL be 16'h0000, +1 per data word, wrapping 16'hFFFF->16'h0000.
REQ-022 PRBS-7 (x^7+x^6+1) and PRBS-31 (x^31+x^28+1) SHALL be seeded all-ones on RUN entry and advance 16 bits per data word, MSB-first.
REQ-023 Any state: ctrl_enable=0 or tx_ready=0 SHALL force IDLE next cycle; a partially sent ALIGN/RUN sequence is discarded, not resumed.
REQ-024 ctrl_mode changes during ALIGN/RUN SHALL be ignored until next ALIGN entry.
REQ-025 tx_cnt SHALL increment once per RUN data word and wrap from 2^48-1 to 0.
REQ-026 Error injection: a rising edge of ctrl_inject_err SHALL invert bit 0 of the next RUN data word only, incrementing tx_err_injected (saturating at 16'hFFFF); pattern state is unaffected.
REQ-027 An injection request arriving outside RUN, or on a comma cycle, SHALL stay pending until the next RUN data word; at most one pending request.
REQ-028 ctrl_clear=1 SHALL zero tx_cnt and tx_err_injected next cycle, overriding a simultaneous increment; pattern and FSM are unaffected.

Reset
REQ-029 rst_n=0 SHALL immediately force: IDLE, tx_data=16'hBC50, tx_charisk=2'b10, tx_cnt=0, tx_err_injected=0, tx_state=00, pending injection cleared, comma-period counter 0.
REQ-030 Release of rst_n SHALL be synchronised internally; first state transition no earlier than 2 txclk after deassertion.

Configuration
REQ-031 With TX_PATTERN_GEN_ERR_INJECT_EN defined, REQ-026/027 logic SHALL be present.
REQ-032 Without TX_PATTERN_GEN_ERR_INJECT_EN, ctrl_inject_err SHALL be ignored, tx_err_injected tied to 0, and data never altered.

Verification
REQ-033 Reset, then tx_ready=1, ctrl_enable=1, mode 00 -> 16 comma words, then 16'h0000,0001,... with charisk 00; tx_cnt=10 after 10 data words.
REQ-034 COMMA_PERIOD=4, counter mode -> data 0,1,2, comma, 3,4,5, comma...; tx_cnt counts data words only.
REQ-035 Mode 01 -> first data words match golden PRBS-7 (seed 7'h7F) model for 1000 words; drop tx_ready mid-RUN -> IDLE commas next cycle; re-enable -> ALIGN, PRBS restarts from seed.
REQ-036 Counter mode, pulse ctrl_inject_err at word 16'h0005 -> one word reads 16'h0007 instead of 16'h0006, next 16'h0007; tx_err_injected=1 (macro on) / no change and 0 (macro off).
REQ-037 ctrl_clear asserted same cycle as a data word -> tx_cnt=0 next cycle; rst_n pulsed mid-RUN -> all outputs at reset values immediately.
